// File: rtl/mdu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mdu_ctrl_pkg -- shared pipeline definitions for the multiply/divide unit.
// Holds the MDU op codes, the default busy-cycle counts and the MDU FSM state
// encodings, so the decoder, hazard unit and mdu_ctrl all agree on them.
// No ports (package).
// -----------------------------------------------------------------------------
package mdu_ctrl_pkg;

  // Default busy-cycle counts for the iterative-latency model.
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Busy down-counter width; comfortably holds either cycle count.
  localparam int CNT_W = 8;

  // MDU op codes carried alongside the start qualifier; 0 and 7 are no-ops.
  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  // FSM state encodings, kept as plain constants for legacy consumers.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;

  // True for the four op codes that occupy the unit for several cycles.
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// -----------------------------------------------------------------------------
// mdu_ctrl_if -- E-stage to MDU handshake bundle.
//   start     : E-stage instruction is an MDU operation (qualifies op)
//   op        : MDU op code (see mdu_ctrl_pkg)
//   rs_val    : forwarded rs operand
//   rt_val    : forwarded rt operand
//   flush     : exception/interrupt flush, aborts the in-flight operation
//   md_use_D  : D-stage instruction touches HI/LO or the MDU
//   busy      : multiply/divide in progress
//   HI, LO    : architectural HI/LO registers
//   md_stall  : stall request into the pipeline stall logic
// master = pipeline side, slave = mdu_ctrl.
// -----------------------------------------------------------------------------
interface mdu_ctrl_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        md_use_D;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        md_stall;

  modport master (
    output start, op, rs_val, rt_val, flush, md_use_D,
    input  busy, HI, LO, md_stall
  );

  modport slave (
    input  start, op, rs_val, rt_val, flush, md_use_D,
    output busy, HI, LO, md_stall
  );
endinterface

// File: rtl/mdu_arith.sv
// -----------------------------------------------------------------------------
// mdu_arith -- purely combinational MDU datapath.
//   op       in  : MDU op code
//   rs_val   in  : rs operand
//   rt_val   in  : rt operand
//   hi_res   out : product[63:32] for mult/multu, remainder for div/divu
//   lo_res   out : product[31:0]  for mult/multu, quotient  for div/divu
//   div_zero out : div/divu with rt_val == 0 (results must not be committed)
// Signed divide truncates toward zero; the remainder takes the dividend's sign.
// -----------------------------------------------------------------------------
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res,
  output logic        div_zero
);

  logic        rt_zero;
  logic [31:0] rt_safe;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic [31:0] quo_u;
  logic [31:0] rem_u;

  assign rt_zero = (rt_val == 32'd0);
  // Substitute a harmless divisor so the dividers never see zero.
  assign rt_safe = rt_zero ? 32'd1 : rt_val;

  // Sign- or zero-extend to 64 bits so the low 64 product bits are exact.
  assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
  assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

  assign quo_s = $signed(rs_val) / $signed(rt_safe);
  assign rem_s = $signed(rs_val) % $signed(rt_safe);
  assign quo_u = rs_val / rt_safe;
  assign rem_u = rs_val % rt_safe;

  always_comb begin
    hi_res   = 32'd0;
    lo_res   = 32'd0;
    div_zero = 1'b0;
    case (op)
      OP_MULT:  begin hi_res = prod_s[63:32]; lo_res = prod_s[31:0]; end
      OP_MULTU: begin hi_res = prod_u[63:32]; lo_res = prod_u[31:0]; end
      OP_DIV:   begin hi_res = rem_s; lo_res = quo_s; div_zero = rt_zero; end
      OP_DIVU:  begin hi_res = rem_u; lo_res = quo_u; div_zero = rt_zero; end
      default:  ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// -----------------------------------------------------------------------------
// mdu_ctrl -- multiply/divide unit controller with a fixed-latency busy model.
//   clk    in : single clock, all state updates on the rising edge
//   reset  in : asynchronous, active-high reset
//   bus       : mdu_ctrl_if.slave (start/op/rs_val/rt_val/flush/md_use_D in,
//               busy/HI/LO/md_stall out)
// The result is computed combinationally at issue and parked in pending
// registers; the FSM then counts MULT_CYCLES or DIV_CYCLES busy cycles and
// commits pending HI/LO on the edge that ends the last busy cycle.
// -----------------------------------------------------------------------------
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input logic       clk,
  input logic       reset,
  mdu_ctrl_if.slave bus
);

  logic [1:0]       state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [31:0]      hi_q,      hi_d;
  logic [31:0]      lo_q,      lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic             pend_wr_q, pend_wr_d;

  logic [31:0]      hi_res;
  logic [31:0]      lo_res;
  logic             div_zero;
  logic             busy;

  mdu_arith u_arith (
    .op       (bus.op),
    .rs_val   (bus.rs_val),
    .rt_val   (bus.rt_val),
    .hi_res   (hi_res),
    .lo_res   (lo_res),
    .div_zero (div_zero)
  );

  assign busy = (state_q != ST_IDLE);

  always_comb begin
    // NOTE: every _d starts from its _q value so no branch can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;

    if (bus.flush) begin
      // Flush wins over everything, including a start in the same cycle.
      state_d   = ST_IDLE;
      cnt_d     = '0;
      pend_hi_d = 32'd0;
      pend_lo_d = 32'd0;
      pend_wr_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            case (bus.op)
              OP_MULT, OP_MULTU: begin
                state_d   = ST_MUL;
                cnt_d     = CNT_W'(MULT_CYCLES);
                pend_hi_d = hi_res;
                pend_lo_d = lo_res;
                pend_wr_d = 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                // Divide-by-zero still takes the full latency but never commits.
                state_d   = ST_DIV;
                cnt_d     = CNT_W'(DIV_CYCLES);
                pend_hi_d = hi_res;
                pend_lo_d = lo_res;
                pend_wr_d = ~div_zero;
              end
              OP_MTHI: hi_d = bus.rs_val;
              OP_MTLO: lo_d = bus.rs_val;
              default: ;
            endcase
          end
        end
        ST_MUL, ST_DIV: begin
          // Starts are ignored while busy; upstream stalls keep them away.
          if (cnt_q <= CNT_W'(1)) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            pend_wr_d = 1'b0;
            if (pend_wr_q) begin
              hi_d = pend_hi_q;
              lo_d = pend_lo_q;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state is written only with non-blocking assignments.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: pending registers are reset as well, so an aborted result can
      // never surface in HI/LO after reset.
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign bus.busy     = busy;
  assign bus.HI       = hi_q;
  assign bus.LO       = lo_q;
  // A D-stage HI/LO user must wait while busy or while an op is being issued.
  assign bus.md_stall = bus.md_use_D & (busy | (bus.start & is_muldiv(bus.op)));

endmodule
